booth_mul_seq: RTL and testbench



---
 rtl/booth_mul_seq.sv | 101 ++++++++++
 tb/tb_booth_mul_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one shared add/sub/shift datapath reused
// over WIDTH+1 cycles behind a start/busy/done handshake, signed or unsigned.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH+1:0]     acc_q;
  logic [WIDTH:0]       q_q;
  logic [WIDTH:0]       m_q;
  logic                 q1_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic [WIDTH:0]       aExt;
  logic [WIDTH:0]       bExt;
  logic [WIDTH+1:0]     mExt;
  logic [WIDTH+1:0]     stepSum;
  logic [WIDTH+1:0]     acc_d;
  logic [WIDTH:0]       q_d;
  logic                 q1_d;

  // One extra bit lets unsigned operands ride through the signed Booth recoding.
  assign aExt = {is_signed & a[WIDTH-1], a};
  assign bExt = {is_signed & b[WIDTH-1], b};

  always_comb begin
    mExt    = {m_q[WIDTH], m_q};
    stepSum = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   stepSum = acc_q + mExt;
      2'b10:   stepSum = acc_q - mExt;
      default: stepSum = acc_q;
    endcase
    {acc_d, q_d, q1_d} = {stepSum[WIDTH+1], stepSum, q_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= aExt;
            q_q     <= bExt;
            q1_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CW'(1);
          // The final step's shifted value goes straight to the product register.
          if (cnt_q == CW'(WIDTH)) begin
            prod_q  <= {acc_d[WIDTH-2:0], q_d};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and random bench for booth_mul_seq at WIDTH 8, 16 and 3, using a
// scoreboard queue filled on operand acceptance and drained on each done pulse.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic start8 = 0, sgn8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy8, done8;
  logic [15:0] prod8;

  logic start16 = 0, sgn16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic busy16, done16;
  logic [31:0] prod16;

  logic start3 = 0, sgn3 = 0;
  logic [2:0] a3 = 0, b3 = 0;
  logic busy3, done3;
  logic [5:0] prod3;

  longint exp8[$], acc8[$], exp16[$], acc16[$], exp3[$], acc3[$];

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8));

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(prod16));

  booth_mul_seq #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .is_signed(sgn3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .product(prod3));

  // Reference product of two w-bit operands, truncated to 2w bits.
  function automatic longint mulModel(bit s, int w, longint x, longint y);
    longint xs = x;
    longint ys = y;
    if (s && x[w-1]) xs = x - (longint'(1) << w);
    if (s && y[w-1]) ys = y - (longint'(1) << w);
    return (xs * ys) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Acceptance happens on an edge where start is high and the block is idle.
  always @(posedge clk) begin
    if (rst_n && start8 && !busy8) begin
      exp8.push_back(mulModel(sgn8, 8, longint'(a8), longint'(b8)));
      acc8.push_back(cyc + 1);
    end
    if (rst_n && start16 && !busy16) begin
      exp16.push_back(mulModel(sgn16, 16, longint'(a16), longint'(b16)));
      acc16.push_back(cyc + 1);
    end
    if (rst_n && start3 && !busy3) begin
      exp3.push_back(mulModel(sgn3, 3, longint'(a3), longint'(b3)));
      acc3.push_back(cyc + 1);
    end
  end

  always @(negedge clk) begin : scoreboard
    longint e, t;
    if (done8) begin
      checkOutput("pending8", longint'(exp8.size() > 0), 1);
      if (exp8.size() > 0) begin
        e = exp8.pop_front();
        t = acc8.pop_front();
        checkOutput("product8", prod8, e[15:0]);
        checkOutput("latency8", cyc - t, 9);
      end
    end
    if (done16) begin
      checkOutput("pending16", longint'(exp16.size() > 0), 1);
      if (exp16.size() > 0) begin
        e = exp16.pop_front();
        t = acc16.pop_front();
        checkOutput("product16", prod16, e[31:0]);
        checkOutput("latency16", cyc - t, 17);
      end
    end
    if (done3) begin
      checkOutput("pending3", longint'(exp3.size() > 0), 1);
      if (exp3.size() > 0) begin
        e = exp3.pop_front();
        t = acc3.pop_front();
        checkOutput("product3", prod3, e[5:0]);
        checkOutput("latency3", cyc - t, 4);
      end
    end
  end

  task automatic waitDone8(output logic [15:0] p);
    int n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout8", done8, 1);
    p = prod8;
  endtask

  task automatic applyStimulus8(input logic s, input logic [7:0] x, input logic [7:0] y,
                                output logic [15:0] p);
    @(negedge clk);
    start8 = 1; sgn8 = s; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 0;
    waitDone8(p);
  endtask

  task automatic applyStimulus16(input logic s, input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    @(negedge clk);
    start16 = 1; sgn16 = s; a16 = x; b16 = y;
    @(negedge clk);
    start16 = 0;
    while (done16 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout16", done16, 1);
  endtask

  task automatic applyStimulus3(input logic s, input logic [2:0] x, input logic [2:0] y);
    int n = 0;
    @(negedge clk);
    start3 = 1; sgn3 = s; a3 = x; b3 = y;
    @(negedge clk);
    start3 = 0;
    while (done3 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout3", done3, 1);
  endtask

  initial begin
    logic [15:0] p;

    #1 rst_n = 0;
    #1;
    checkOutput("rst_busy8", busy8, 0);
    checkOutput("rst_done8", done8, 0);
    checkOutput("rst_prod8", prod8, 0);
    checkOutput("rst_prod16", prod16, 0);
    checkOutput("rst_prod3", prod3, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    applyStimulus8(1, 8'hF0, 8'hF0, p);
    checkOutput("s_f0_f0", p, 16'h0100);
    applyStimulus8(1, 8'h80, 8'h80, p);
    checkOutput("s_80_80", p, 16'h4000);
    applyStimulus8(0, 8'hFF, 8'hFF, p);
    checkOutput("u_ff_ff", p, 16'hFE01);
    applyStimulus8(1, 8'hFF, 8'hFF, p);
    checkOutput("s_ff_ff", p, 16'h0001);

    // Start held high across two operations; operands change in the done cycle.
    @(negedge clk);
    start8 = 1; sgn8 = 1; a8 = 8'd7; b8 = 8'd3;
    waitDone8(p);
    checkOutput("b2b_first", p, 16'd21);
    a8 = 8'hFB; b8 = 8'd6;
    @(negedge clk);
    waitDone8(p);
    start8 = 0;
    checkOutput("b2b_second", p, 16'hFFE2);

    // A start pulse during RUN must be ignored.
    @(negedge clk);
    start8 = 1; sgn8 = 0; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    start8 = 1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 0;
    checkOutput("busy_during_ignored", busy8, 1);
    waitDone8(p);
    checkOutput("ignored_result", p, 16'h03A8);

    // Asynchronous abort partway through an operation.
    @(negedge clk);
    start8 = 1; sgn8 = 1; a8 = 8'h55; b8 = 8'h22;
    @(negedge clk);
    start8 = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_done", done8, 0);
    checkOutput("abort_prod", prod8, 0);
    exp8.delete();
    acc8.delete();
    @(negedge clk);
    rst_n = 1;
    applyStimulus8(0, 8'h3C, 8'h05, p);
    checkOutput("after_abort", p, 16'h012C);

    applyStimulus8(0, 8'h07, 8'h00, p);
    checkOutput("mul_zero", p, 16'h0000);
    applyStimulus8(1, 8'h01, 8'h01, p);
    checkOutput("mul_one", p, 16'h0001);
    applyStimulus8(1, 8'h7F, 8'h81, p);
    checkOutput("s_7f_81", p, 16'hC0FF);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      applyStimulus3(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    repeat (3) @(negedge clk);
    checkOutput("drained8", exp8.size(), 0);
    checkOutput("drained16", exp16.size(), 0);
    checkOutput("drained3", exp3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
